// File: rtl/spi_lcd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_lcd_sequencer                                            |
// | Description : Byte queue feeding an SPI transmit controller, with gaps and |
// |               a transfer timeout. Optional delay entries: LCD_SEQ_DELAY_EN |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module spi_lcd_sequencer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int PTR_W          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DELAY_UNIT     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             wr_dc,
`ifdef LCD_SEQ_DELAY_EN
  input  logic             wr_delay,
`endif
  input  logic             flush,
  input  logic             clr_status,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [PTR_W:0]   fifo_level,
  output logic             seq_busy,
  output logic             overflow,
  output logic             timeout_err,
  output logic [15:0]      sent_count,
  output logic             spi_start,
  output logic [7:0]       spi_data_out,
  output logic             spi_dc_out,
  input  logic             spi_busy,
  input  logic             spi_done
);

`ifdef LCD_SEQ_DELAY_EN
  localparam int c_ENTRY_W = 10;
`else
  localparam int c_ENTRY_W = 9;
`endif
  localparam int c_DLY_MAX = 255 * DELAY_UNIT;
  localparam int c_CNT_MAX = (TIMEOUT_CYCLES > c_DLY_MAX)
                             ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                             : ((c_DLY_MAX > GAP_CYCLES) ? c_DLY_MAX : GAP_CYCLES);
  localparam int c_CNT_W = $clog2(c_CNT_MAX + 1);
  localparam logic [PTR_W:0] c_DEPTH = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
`ifdef LCD_SEQ_DELAY_EN
    S_DELAY     = 3'd4,
`endif
    S_GAP       = 3'd3
  } state_t;

  logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_level;
  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_val;
  logic                 w_cnt_load, w_cnt_dec;
  logic                 w_pop, w_push, w_full, w_empty, w_start;
  logic                 w_done_evt, w_timeout_evt, w_ovf_evt;
  logic                 r_overflow, r_timeout_err, r_dc;
  logic [15:0]          r_sent_count;
  logic [7:0]           r_data;
  logic [c_ENTRY_W-1:0] w_head, w_wr_entry;
  logic                 w_head_dly;

  assign w_full  = (r_level == c_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];
`ifdef LCD_SEQ_DELAY_EN
  assign w_wr_entry = {wr_delay, wr_dc, wr_data};
  assign w_head_dly = w_head[9];
`else
  assign w_wr_entry = {wr_dc, wr_data};
  assign w_head_dly = 1'b0;
`endif

  // A write into a full queue is lost even if a pop frees a slot this cycle
  assign w_push    = wr_en && !flush && !w_full;
  assign w_ovf_evt = wr_en && !flush && w_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_start       = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_val     = '0;
    w_cnt_dec     = 1'b0;
    w_done_evt    = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A stray spi_done here (e.g. after reset mid-transfer) blocks the pop
        if (!w_empty && !spi_busy && !spi_done && !flush) begin
          w_pop = 1'b1;
`ifdef LCD_SEQ_DELAY_EN
          if (w_head_dly) begin
            w_state_nxt = S_DELAY;
            w_cnt_load  = 1'b1;
            w_cnt_val   = (w_head[7:0] == 8'd0) ? c_CNT_W'(1)
                          : c_CNT_W'(w_head[7:0]) * c_CNT_W'(DELAY_UNIT);
          end else begin
            w_state_nxt = S_ISSUE;
          end
`else
          w_state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT_DONE;
        w_cnt_load  = 1'b1;
        w_cnt_val   = c_CNT_W'(TIMEOUT_CYCLES);
      end
      S_WAIT_DONE: begin
        if (spi_done) begin
          w_done_evt = 1'b1;
          if (GAP_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_load  = 1'b1;
            w_cnt_val   = c_CNT_W'(GAP_CYCLES);
          end
        end else if (r_cnt <= c_CNT_W'(1)) begin
          w_timeout_evt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
`ifdef LCD_SEQ_DELAY_EN
      S_DELAY: begin
        if (r_cnt <= c_CNT_W'(1)) w_state_nxt = S_IDLE;
        else                      w_cnt_dec   = 1'b1;
      end
`endif
      S_GAP: begin
        if (r_cnt <= c_CNT_W'(1)) w_state_nxt = S_IDLE;
        else                      w_cnt_dec   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_cnt <= '0;
    else if (w_cnt_load) r_cnt <= w_cnt_val;
    else if (w_cnt_dec)  r_cnt <= r_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_dc   <= 1'b0;
    end else if (w_pop && !w_head_dly) begin
      r_data <= w_head[7:0];
      r_dc   <= w_head[8];
    end
  end

  // Set events take precedence over clr_status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sent_count  <= '0;
    end else begin
      if (w_ovf_evt)       r_overflow <= 1'b1;
      else if (clr_status) r_overflow <= 1'b0;
      if (w_timeout_evt)   r_timeout_err <= 1'b1;
      else if (clr_status) r_timeout_err <= 1'b0;
      if (w_done_evt)      r_sent_count <= r_sent_count + 16'd1;
      else if (clr_status) r_sent_count <= '0;
    end
  end

  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign fifo_level   = r_level;
  assign seq_busy     = (r_state != S_IDLE) || !w_empty;
  assign overflow     = r_overflow;
  assign timeout_err  = r_timeout_err;
  assign sent_count   = r_sent_count;
  assign spi_start    = w_start;
  assign spi_data_out = r_data;
  assign spi_dc_out   = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_spi_lcd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_lcd_sequencer                                         |
// | Description : Randomized bench with an SPI controller model and a byte     |
// |               scoreboard for spi_lcd_sequencer                             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_spi_lcd_sequencer;
  localparam int FIFO_DEPTH     = 16;
  localparam int PTR_W          = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int DELAY_UNIT     = 1000;

  logic clk = 1'b0, reset = 1'b1;
  logic wr_en = 1'b0, wr_dc = 1'b0, flush = 1'b0, clr_status = 1'b0;
  logic [7:0] wr_data = 8'd0;
`ifdef LCD_SEQ_DELAY_EN
  logic wr_delay = 1'b0;
`endif
  logic fifo_full, fifo_empty, seq_busy, overflow, timeout_err;
  logic [PTR_W:0] fifo_level;
  logic [15:0] sent_count;
  logic spi_start, spi_dc_out, spi_busy, spi_done;
  logic [7:0] spi_data_out;

  spi_lcd_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DELAY_UNIT(DELAY_UNIT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dc(wr_dc),
`ifdef LCD_SEQ_DELAY_EN
    .wr_delay(wr_delay),
`endif
    .flush(flush), .clr_status(clr_status), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .seq_busy(seq_busy),
    .overflow(overflow), .timeout_err(timeout_err), .sent_count(sent_count),
    .spi_start(spi_start), .spi_data_out(spi_data_out), .spi_dc_out(spi_dc_out),
    .spi_busy(spi_busy), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [8:0] exp_q[$];            // bytes written and not yet seen on spi_start
  int  n_starts = 0, n_done = 0, last_start_cyc = 0, last_done_cyc = 0, wr_cyc = 0;
  int  spi_lat = 20, drop_cnt = 0, period_ref = -1;
  bit  force_busy = 1'b0, chk_period = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI controller model plus scoreboard of every byte that reaches spi_start
  initial begin : spi_model
    int left;
    left = 0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          spi_done = 1'b1;
          n_done++;
          last_done_cyc = cyc;
        end
      end
      if (spi_start) begin
        n_starts++;
        if (chk_period) begin
          if (period_ref >= 0) chk("byte_period", cyc - period_ref, spi_lat + GAP_CYCLES + 2);
          period_ref = cyc;
        end
        last_start_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else chk("start_byte", 32'({spi_dc_out, spi_data_out}), 32'(exp_q.pop_front()));
        if (drop_cnt > 0) drop_cnt--;
        else left = spi_lat;
      end
      spi_busy = force_busy || (left > 0);
    end
  end

  // Called at a negedge; returns one negedge later with wr_en low
  task automatic push(input logic [7:0] d, input logic dc, input logic dly);
    wr_en = 1'b1; wr_data = d; wr_dc = dc;
`ifdef LCD_SEQ_DELAY_EN
    wr_delay = dly;
`endif
    if (!dly && exp_q.size() < FIFO_DEPTH) exp_q.push_back({dc, d});
    wr_cyc = cyc;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin @(negedge clk); n++; end
    chk("start_seen", 32'(n_starts >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((seq_busy || spi_busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("idle_reached", 32'(n < budget), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, 32'({fifo_full, fifo_empty, seq_busy, overflow, timeout_err,
                              spi_start, spi_dc_out}), 32'b0100000);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_count"}, 32'(sent_count), 32'd0);
    chk({tag, "_data"},  32'(spi_data_out), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int s0, d0, t;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Single command byte, latency and return to idle
    spi_lat = 20;
    s0 = n_starts;
    push(8'h2A, 1'b0, 1'b0);
    wait_starts(s0 + 1, 10);
    chk("first_latency", last_start_cyc - wr_cyc, 2);
    wait_dones(n_done + 1, 40);
    d0 = last_done_cyc;
    t = 0;
    while (seq_busy && t < 30) begin @(negedge clk); t++; end
    chk("idle_after_done", cyc - d0, GAP_CYCLES + 1);
    chk("sent_one", 32'(sent_count), 32'd1);
    chk("data_hold", 32'({spi_dc_out, spi_data_out}), 32'h02A);

    // Fill past capacity with the controller stalled, then drain
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < FIFO_DEPTH; i++) push(8'($urandom), 1'($urandom), 1'b0);
    chk("full_at_depth", 32'({fifo_full, overflow}), 32'b10);
    chk("level_at_depth", 32'(fifo_level), FIFO_DEPTH);
    push(8'hEE, 1'b1, 1'b0);
    chk("overflow_set", 32'({fifo_full, overflow}), 32'b11);
    chk("level_after_drop", 32'(fifo_level), FIFO_DEPTH);
    spi_lat = 5;
    period_ref = -1;
    chk_period = 1'b1;
    force_busy = 1'b0;
    wait_idle(1000);
    chk_period = 1'b0;
    chk("sent_after_drain", 32'(sent_count), 32'd17);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    chk("clr_status", 32'({overflow, timeout_err}), 32'd0);
    chk("clr_count", 32'(sent_count), 32'd0);

    // Controller never answers the first byte
    spi_lat = 4;
    drop_cnt = 1;
    push(8'h36, 1'b0, 1'b0);
    push(8'h48, 1'b1, 1'b0);
    t = 0;
    while (!timeout_err && t < TIMEOUT_CYCLES + 50) begin @(negedge clk); t++; end
    chk("timeout_latency", cyc - last_start_cyc, TIMEOUT_CYCLES + 1);
    wait_idle(200);
    chk("sent_after_timeout", 32'(sent_count), 32'd1);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    pulse_clr();
    chk("timeout_cleared", 32'(timeout_err), 32'd0);

    // Flush while the first of four bytes is in flight
    pulse_clr();
    spi_lat = 30;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push(8'($urandom), 1'b1, 1'b0);
    wait_starts(s0 + 1, 10);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    wr_en = 1'b1; wr_data = 8'h99;   // dropped: flush wins
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_level", 32'({fifo_empty, fifo_level}), 32'({1'b1, 5'd0}));
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("flush_sent", 32'(sent_count), 32'd1);
    chk("flush_starts", n_starts - s0, 1);

`ifdef LCD_SEQ_DELAY_EN
    // Delay entry between two bytes
    pulse_clr();
    spi_lat = 5;
    s0 = n_starts;
    push(8'h11, 1'b0, 1'b0);
    push(8'd3, 1'b0, 1'b1);
    push(8'h29, 1'b0, 1'b0);
    wait_starts(s0 + 2, 3 * DELAY_UNIT + 500);
    chk("delay_gap", 32'((last_start_cyc - last_done_cyc) >= 3 * DELAY_UNIT), 32'd1);
    wait_idle(200);
    chk("delay_sent", 32'(sent_count), 32'd2);
`endif

    // Random traffic with random transfer times
    pulse_clr();
    for (int i = 0; i < 40; i++) begin
      while (exp_q.size() >= 8) @(negedge clk);
      spi_lat = $urandom_range(1, 12);
      b = 8'($urandom);
      push(b, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(3000);
    chk("rand_sent", 32'(sent_count), 32'd40);

    // Reset during WAIT_DONE, then the stale spi_done arrives
    spi_lat = 40;
    s0 = n_starts;
    d0 = n_done;
    push(8'h5A, 1'b1, 1'b0);
    wait_starts(s0 + 1, 10);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    wait_dones(d0 + 1, 60);
    repeat (8) @(negedge clk);
    chk("stale_done_count", 32'(sent_count), 32'd0);
    chk("stale_done_starts", n_starts - s0, 1);
    chk("stale_done_busy", 32'(seq_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_lcd_sequencer.md
Name: spi_lcd_sequencer

Overview:
- Queues LCD command/data bytes and feeds them one at a time into the byte-level SPI transmit controller (spi_start / spi_data_in / spi_dc in, spi_busy / spi_done out).
- Sits between the CPU-side bus register block and the SPI controller, so software can burst-write a command stream without polling per byte.
- Inserts programmable inter-byte gaps and watches for a hung transfer with a timeout.

Parameters:
- FIFO_DEPTH, 16, entries in the byte queue; power of two, at least 2.
- PTR_W, 4, log2(FIFO_DEPTH).
- GAP_CYCLES, 2, idle clocks between a spi_done and the next spi_start; 0 means back-to-back.
- TIMEOUT_CYCLES, 1024, maximum clocks allowed in WAIT_DONE before the error abort.
- DELAY_UNIT, 1000, clocks per delay tick; used only with LCD_SEQ_DELAY_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  push one entry this cycle
- wr_data  in  8  byte, or delay tick count when wr_delay=1
- wr_dc  in  1  0=command, 1=data
- wr_delay  in  1  entry is a delay, not a byte; exists only with LCD_SEQ_DELAY_EN
- flush  in  1  discard all queued entries
- clr_status  in  1  clear overflow, timeout_err and sent_count
- fifo_full  out  1  queue full
- fifo_empty  out  1  queue empty
- fifo_level  out  PTR_W+1  current number of entries
- seq_busy  out  1  high when the FSM is not in IDLE or the queue is non-empty
- overflow  out  1  sticky; set when a write is dropped
- timeout_err  out  1  sticky; set when WAIT_DONE times out
- sent_count  out  16  bytes completed, wraps at 16'hFFFF to 0
- spi_start  out  1  one-cycle start pulse to the SPI controller
- spi_data_out  out  8  byte to the SPI controller; held stable from spi_start until spi_done
- spi_dc_out  out  1  D/C flag to the SPI controller
- spi_busy  in  1  from the SPI controller
- spi_done  in  1  one-cycle completion pulse from the SPI controller

Behaviour:
- Reset values: all outputs 0 except fifo_empty=1. Reset also clears the pointers, counters and FSM (to IDLE). Reset mid-transfer abandons the in-flight byte; any later spi_done arriving while in IDLE is ignored.
- FIFO:
  - Entry = {delay, dc, data}. Pointers wrap modulo FIFO_DEPTH.
  - A write when fifo_full=1 (registered) is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A pop only occurs on the IDLE->ISSUE or IDLE->DELAY transition.
  - Simultaneous push and pop when not full: level is unchanged.
- FSM:
  - IDLE: when !fifo_empty, !spi_busy and !spi_done, pop the head entry; a byte goes to ISSUE, a delay entry goes to DELAY.
  - ISSUE: drive spi_start=1 for exactly this cycle, with spi_data_out/spi_dc_out already valid; go to WAIT_DONE and load the timeout counter.
  - WAIT_DONE: on spi_done, increment sent_count and go to GAP (or to IDLE if GAP_CYCLES=0). If the counter reaches 0 first, set timeout_err and go to IDLE.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
  - DELAY: count data×DELAY_UNIT clocks, then go to IDLE; data=0 means exactly 1 clock.
- Latency: a write accepted at edge k into an empty queue with an idle SPI controller gives spi_start high in the cycle after edge k+1.
- Steady-state byte period = SPI transfer time + GAP_CYCLES + 2 clocks.
- flush: empties the queue in the same edge and has priority over a simultaneous wr_en. An in-flight byte (WAIT_DONE/GAP) still completes and is counted.
- clr_status: takes effect on the same edge. If it coincides with a set event, the set event wins.

Optional Feature:
- Macro LCD_SEQ_DELAY_EN.
- Defined: the wr_delay port and DELAY state exist, and entries carry a delay bit, e.g. for LCD post-reset/sleep-out waits.
- Undefined: no wr_delay port, no DELAY state, entries are 9 bits, and every entry is sent as an SPI byte.

Test Plan:
- Write 0x2A (dc=0) to an idle block, with the bench SPI model asserting spi_done 20 clocks after start -> spi_start 2 clocks after the write; spi_data_out=0x2A, spi_dc_out=0; sent_count=1; seq_busy low GAP_CYCLES+1 clocks after spi_done.
- Burst-write 17 bytes with FIFO_DEPTH=16 and the SPI model stalled -> fifo_full=1 after 16 writes, overflow=1 and the 17th byte never transmitted; release the model -> exactly 16 bytes sent in order.
- SPI model never returns spi_done -> timeout_err=1 after TIMEOUT_CYCLES clocks in WAIT_DONE, FSM returns to IDLE, the next queued byte is issued; clr_status clears the flag.
- Queue 4 bytes, assert flush while the first byte is in WAIT_DONE -> the first byte completes (sent_count=1), fifo_level=0, no further spi_start.
- Assert reset during WAIT_DONE, then inject a stale spi_done -> all outputs return to reset values and no spi_start or count change follows.
- With LCD_SEQ_DELAY_EN: queue byte 0x11, a delay entry with data=3, then byte 0x29 -> at least 3×DELAY_UNIT clocks between the spi_done for 0x11 and the spi_start for 0x29; sent_count=2.
